// File: rtl/kbd_calc_ctrl.sv
// Keyboard calculator sequencer: two 2-digit operands, add/sub(/mul), double-dabble to BCD.
// Optional multiply key enabled by defining KBD_CALC_MUL_EN.
module kbd_calc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [8:0]  last_change,
  output logic [15:0] disp_bcd,
  output logic        disp_neg,
  output logic [1:0]  op_code,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CONV = 2'd2, S_SHOW = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  a_tens_reg, a_tens_next, a_ones_reg, a_ones_next;
  logic [3:0]  b_tens_reg, b_tens_next, b_ones_reg, b_ones_next;
  logic [1:0]  op_reg, op_next;
  logic [13:0] bin_reg, bin_next;
  logic [15:0] bcd_reg, bcd_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        sign_reg, sign_next;
  logic [15:0] disp_reg, disp_next;
  logic        neg_reg, neg_next;
  logic        done_reg, done_next;

  logic        is_digit, is_op, is_enter;
  logic [3:0]  key_digit;
  logic [1:0]  key_op;

  // Extended (bit 8) and unknown codes decode to nothing at all.
  always_comb begin
    is_digit  = 1'b0;
    is_op     = 1'b0;
    is_enter  = 1'b0;
    key_digit = 4'd0;
    key_op    = 2'd0;
    if (key_valid && !last_change[8]) begin
      case (last_change[7:0])
        8'h45: begin is_digit = 1'b1; key_digit = 4'd0; end
        8'h16: begin is_digit = 1'b1; key_digit = 4'd1; end
        8'h1E: begin is_digit = 1'b1; key_digit = 4'd2; end
        8'h26: begin is_digit = 1'b1; key_digit = 4'd3; end
        8'h25: begin is_digit = 1'b1; key_digit = 4'd4; end
        8'h2E: begin is_digit = 1'b1; key_digit = 4'd5; end
        8'h36: begin is_digit = 1'b1; key_digit = 4'd6; end
        8'h3D: begin is_digit = 1'b1; key_digit = 4'd7; end
        8'h3E: begin is_digit = 1'b1; key_digit = 4'd8; end
        8'h46: begin is_digit = 1'b1; key_digit = 4'd9; end
        8'h1C: begin is_op = 1'b1; key_op = 2'd0; end
        8'h1B: begin is_op = 1'b1; key_op = 2'd1; end
`ifdef KBD_CALC_MUL_EN
        8'h3A: begin is_op = 1'b1; key_op = 2'd2; end
`endif
        8'h5A: is_enter = 1'b1;
        default: ;
      endcase
    end
  end

  logic [6:0]  a_bin, b_bin;
  logic [13:0] res_mag;
  logic        res_neg;

  assign a_bin = {3'd0, a_tens_reg} * 7'd10 + {3'd0, a_ones_reg};
  assign b_bin = {3'd0, b_tens_reg} * 7'd10 + {3'd0, b_ones_reg};

  always_comb begin
    res_mag = {7'd0, a_bin} + {7'd0, b_bin};
    res_neg = 1'b0;
    case (op_reg)
      2'd1: begin
        if (a_bin >= b_bin) begin
          res_mag = {7'd0, a_bin - b_bin};
        end else begin
          res_mag = {7'd0, b_bin - a_bin};
          res_neg = 1'b1;
        end
      end
`ifdef KBD_CALC_MUL_EN
      2'd2: res_mag = {7'd0, a_bin} * {7'd0, b_bin};
`endif
      default: ;
    endcase
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift the BCD:binary pair left.
  logic [15:0] bcd_adj, bcd_shift;
  logic [13:0] bin_shift;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[14:0], bin_reg[13]};
  assign bin_shift = {bin_reg[12:0], 1'b0};

  always_comb begin
    state_next  = state_reg;
    a_tens_next = a_tens_reg;
    a_ones_next = a_ones_reg;
    b_tens_next = b_tens_reg;
    b_ones_next = b_ones_reg;
    op_next     = op_reg;
    bin_next    = bin_reg;
    bcd_next    = bcd_reg;
    cnt_next    = cnt_reg;
    sign_next   = sign_reg;
    disp_next   = disp_reg;
    neg_next    = neg_reg;
    done_next   = 1'b0;
    case (state_reg)
      S_A: begin
        disp_next = {8'h00, a_tens_reg, a_ones_reg};
        neg_next  = 1'b0;
        if (is_digit) begin
          a_tens_next = a_ones_reg;
          a_ones_next = key_digit;
        end else if (is_op) begin
          op_next     = key_op;
          b_tens_next = 4'd0;
          b_ones_next = 4'd0;
          state_next  = S_B;
        end
      end
      S_B: begin
        disp_next = {8'h00, b_tens_reg, b_ones_reg};
        neg_next  = 1'b0;
        if (is_digit) begin
          b_tens_next = b_ones_reg;
          b_ones_next = key_digit;
        end else if (is_op) begin
          op_next = key_op;
        end else if (is_enter) begin
          bin_next   = res_mag;
          sign_next  = res_neg;
          bcd_next   = 16'h0000;
          cnt_next   = 4'd0;
          state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_reg == 4'd14) begin
          disp_next  = bcd_reg;
          neg_next   = sign_reg;
          done_next  = 1'b1;
          state_next = S_SHOW;
        end else begin
          bcd_next = bcd_shift;
          bin_next = bin_shift;
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_SHOW: begin
        if (is_digit || is_enter) begin
          a_tens_next = 4'd0;
          a_ones_next = is_digit ? key_digit : 4'd0;
          b_tens_next = 4'd0;
          b_ones_next = 4'd0;
          state_next  = S_A;
        end
      end
      default: state_next = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_A;
      a_tens_reg <= 4'd0;
      a_ones_reg <= 4'd0;
      b_tens_reg <= 4'd0;
      b_ones_reg <= 4'd0;
      op_reg     <= 2'd0;
      bin_reg    <= 14'd0;
      bcd_reg    <= 16'h0000;
      cnt_reg    <= 4'd0;
      sign_reg   <= 1'b0;
      disp_reg   <= 16'h0000;
      neg_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_tens_reg <= a_tens_next;
      a_ones_reg <= a_ones_next;
      b_tens_reg <= b_tens_next;
      b_ones_reg <= b_ones_next;
      op_reg     <= op_next;
      bin_reg    <= bin_next;
      bcd_reg    <= bcd_next;
      cnt_reg    <= cnt_next;
      sign_reg   <= sign_next;
      disp_reg   <= disp_next;
      neg_reg    <= neg_next;
      done_reg   <= done_next;
    end
  end

  assign disp_bcd = disp_reg;
  assign disp_neg = neg_reg;
  assign op_code  = op_reg;
  assign busy     = (state_reg == S_CONV);
  assign done     = done_reg;

endmodule

// File: tb/tb_kbd_calc_ctrl.sv
// Directed bench for kbd_calc_ctrl; honours KBD_CALC_MUL_EN for the multiply vector.
module tb_kbd_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [8:0]  last_change;
  logic [15:0] disp_bcd;
  logic        disp_neg;
  logic [1:0]  op_code;
  logic        busy;
  logic        done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  kbd_calc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .disp_bcd    (disp_bcd),
    .disp_neg    (disp_neg),
    .op_code     (op_code),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One key pulse, then two idle cycles so the display register has caught up.
  task automatic press(input logic [8:0] code);
    @(negedge clk);
    last_change = code;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid   = 1'b0;
    last_change = 9'h000;
    @(negedge clk);
    @(negedge clk);
    $display("key %03h -> disp_bcd=%04h neg=%0b op=%0d busy=%0b", code, disp_bcd, disp_neg, op_code, busy);
  endtask

  task automatic run_enter(input string tag, input logic [15:0] exp_bcd, input logic exp_neg,
                           input bit inject);
    int busy_cnt   = 0;
    bit done_early = 1'b0;
    @(negedge clk);
    last_change = 9'h05A;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key_valid = 1'b0;
      if (!busy) break;
      if (done) done_early = 1'b1;
      busy_cnt++;
      if (inject && busy_cnt == 3) begin last_change = 9'h03D; key_valid = 1'b1; end
      if (inject && busy_cnt == 6) begin last_change = 9'h05A; key_valid = 1'b1; end
      @(negedge clk);
    end
    key_valid = 1'b0;
    $display("enter %s -> busy_cycles=%0d disp_bcd=%04h neg=%0b done=%0b", tag, busy_cnt, disp_bcd, disp_neg, done);
    check({tag, "_busy_cycles"}, busy_cnt, 15);
    check({tag, "_done_early"}, {31'd0, done_early}, 0);
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_bcd"}, {16'd0, disp_bcd}, {16'd0, exp_bcd});
    check({tag, "_neg"}, {31'd0, disp_neg}, {31'd0, exp_neg});
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 0);
  endtask

  initial begin
    bit done_seen;
    rst         = 1'b1;
    key_valid   = 1'b0;
    last_change = 9'h000;
    repeat (3) @(negedge clk);
    check("rst_bcd",  {16'd0, disp_bcd}, 32'h0);
    check("rst_neg",  {31'd0, disp_neg}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_op",   {30'd0, op_code}, 0);
    rst = 1'b0;

    // 12 + 34
    press(9'h016); press(9'h01E);
    check("a_12", {16'd0, disp_bcd}, 32'h0012);
    press(9'h01C);
    check("op_add", {30'd0, op_code}, 0);
    check("b_clear", {16'd0, disp_bcd}, 32'h0000);
    press(9'h026); press(9'h025);
    check("b_34", {16'd0, disp_bcd}, 32'h0034);
    run_enter("add", 16'h0046, 1'b0, 1'b0);

    // 5 - 17 = -12
    press(9'h05A);
    check("show_enter_clr", {16'd0, disp_bcd}, 32'h0000);
    press(9'h045); press(9'h02E);
    check("a_05", {16'd0, disp_bcd}, 32'h0005);
    press(9'h01B);
    check("op_sub", {30'd0, op_code}, 1);
    press(9'h016); press(9'h03D);
    check("b_17", {16'd0, disp_bcd}, 32'h0017);
    run_enter("sub", 16'h0012, 1'b1, 1'b0);

    // 99 * 99, or an ignored 0x3A when multiply is absent
    press(9'h05A);
    check("show_enter_neg", {31'd0, disp_neg}, 0);
    press(9'h046); press(9'h046); press(9'h03A); press(9'h046); press(9'h046);
`ifdef KBD_CALC_MUL_EN
    check("op_mul", {30'd0, op_code}, 2);
    run_enter("mul", 16'h9801, 1'b0, 1'b0);
`else
    check("nomul_a99", {16'd0, disp_bcd}, 32'h0099);
    check("nomul_op", {30'd0, op_code}, 1);
    press(9'h05A);
    check("nomul_enter_ignored", {31'd0, busy}, 0);
    check("nomul_still_a", {16'd0, disp_bcd}, 32'h0099);
`endif

    // Shift-in keeps last two digits; extended and unknown codes ignored
    press(9'h016); press(9'h01E); press(9'h026);
    check("a_23", {16'd0, disp_bcd}, 32'h0023);
    press(9'h116);
    check("ext_ignored", {16'd0, disp_bcd}, 32'h0023);
    press(9'h029);
    check("unknown_ignored", {16'd0, disp_bcd}, 32'h0023);
    press(9'h045);
    check("a_30", {16'd0, disp_bcd}, 32'h0030);

    // Keys dropped during conversion: 30 + 5
    press(9'h01C); press(9'h02E);
    check("b_05", {16'd0, disp_bcd}, 32'h0005);
    run_enter("inject", 16'h0035, 1'b0, 1'b1);
    press(9'h025);
    check("show_digit", {16'd0, disp_bcd}, 32'h0004);
    check("show_digit_busy", {31'd0, busy}, 0);

    // Operator replacement, then reset mid-conversion with a coincident key
    press(9'h01C); press(9'h01B);
    check("op_replace", {30'd0, op_code}, 1);
    press(9'h046);
    @(negedge clk);
    last_change = 9'h05A;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("conv_busy", {31'd0, busy}, 1);
    repeat (6) @(negedge clk);
    rst         = 1'b1;
    last_change = 9'h016;
    key_valid   = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    $display("reset at E+7 -> disp_bcd=%04h busy=%0b done=%0b op=%0d", disp_bcd, busy, done, op_code);
    check("mid_rst_bcd",  {16'd0, disp_bcd}, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_neg",  {31'd0, disp_neg}, 0);
    check("mid_rst_op",   {30'd0, op_code}, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, done_seen}, 0);
    check("rst_key_ignored", {16'd0, disp_bcd}, 32'h0);
    press(9'h03E);
    check("after_rst_s_a", {16'd0, disp_bcd}, 32'h0008);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
